// File: rtl/dmem_pkg.sv
// Shared constants for the data-side responder: MMIO map, STATUS layout and
// the UART transmitter state encoding.
package dmem_pkg;

    localparam logic [31:0] MMIO_BASE  = 32'h1000_0000;

    localparam logic [3:0]  OFF_LED    = 4'h0;
    localparam logic [3:0]  OFF_TXDATA = 4'h4;
    localparam logic [3:0]  OFF_STATUS = 4'h8;
    localparam logic [3:0]  OFF_CYCLE  = 4'hC;

    localparam int STAT_FULL     = 0;
    localparam int STAT_EMPTY    = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_OVERFLOW = 3;

    typedef enum logic [1:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP
    } uart_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// Memory-stage data port between the core (master) and the responder (slave).
interface dmem_responder_if;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output addr, output we, output wdata, input rdata);
    modport slave  (input addr, input we, input wdata, output rdata);
endinterface

// File: rtl/uart_tx_core.sv
// Byte FIFO feeding an 8N1 serial transmitter; the FSM pops one byte per frame.
module uart_tx_core
    import dmem_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_push,
    input  logic [7:0] i_pushData,
    output logic       o_full,
    output logic       o_empty,
    output logic       o_busy,
    output logic       o_overflowSet,
    output logic       o_tx
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
    localparam logic [PW:0]   COUNT_FULL = (PW + 1)'(FIFO_DEPTH);

    logic [7:0]    r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wrPtr;
    logic [PW-1:0] r_rdPtr;
    logic [PW:0]   r_count;

    uart_state_e   r_state;
    uart_state_e   w_nextState;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bitCnt;
    logic [7:0]    r_shift;

    logic w_pop;
    logic w_pushOk;
    logic w_baudEnd;

    assign o_full        = (r_count == COUNT_FULL);
    assign o_empty       = (r_count == '0);
    assign o_busy        = (r_state != UART_IDLE);
    assign w_pop         = (r_state == UART_IDLE) && !o_empty;
    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign w_pushOk      = i_push && (!o_full || w_pop);
    assign o_overflowSet = i_push && o_full && !w_pop;
    assign w_baudEnd     = (r_baud == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_fifo[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_pushOk, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= UART_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        o_tx        = 1'b1;
        case (r_state)
            UART_IDLE: begin
                if (w_pop) begin
                    w_nextState = UART_START;
                end
            end
            UART_START: begin
                o_tx = 1'b0;
                if (w_baudEnd) begin
                    w_nextState = UART_DATA;
                end
            end
            UART_DATA: begin
                o_tx = r_shift[0];
                if (w_baudEnd && (r_bitCnt == 3'd7)) begin
                    w_nextState = UART_STOP;
                end
            end
            UART_STOP: begin
                if (w_baudEnd) begin
                    w_nextState = UART_IDLE;
                end
            end
            default: w_nextState = UART_IDLE;
        endcase
    end

    // The baud counter restarts on every bit boundary and is held at zero while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_baud   <= '0;
            r_bitCnt <= '0;
            r_shift  <= '0;
        end else begin
            if ((r_state == UART_IDLE) || w_baudEnd) begin
                r_baud <= '0;
            end else begin
                r_baud <= r_baud + 1'b1;
            end
            if (w_pop) begin
                r_shift <= r_fifo[r_rdPtr];
            end else if ((r_state == UART_DATA) && w_baudEnd) begin
                r_shift <= r_shift >> 1;
            end
            if ((r_state == UART_DATA) && w_baudEnd) begin
                r_bitCnt <= r_bitCnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Far end of the core's data port: word RAM plus LED, cycle counter and UART TX
// registers, with a zero-wait-state combinational read path.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int MEM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8,
    parameter int CLK_DIV    = 868
) (
    input  logic             clk,
    input  logic             reset,
    dmem_responder_if.slave  bus,
    output logic [7:0]       leds,
    output logic             uart_tx
);
    localparam int AW = $clog2(MEM_WORDS);

    logic [31:0] r_mem [MEM_WORDS];
    logic [7:0]  r_leds;
    logic [31:0] r_cycle;
    logic        r_overflow;

    logic          w_ramSel;
    logic          w_mmioSel;
    logic [3:0]    w_offset;
    logic [AW-1:0] w_ramIdx;
    logic          w_mmioWr;
    logic          w_ledWr;
    logic          w_txPush;
    logic          w_statusWr;
    logic          w_cycleWr;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic          w_overflowSet;
    logic [3:0]    w_status;
    logic          w_unusedAddr;

    assign w_ramSel     = (bus.addr[31:AW+2] == '0);
    assign w_mmioSel    = (bus.addr[31:4] == MMIO_BASE[31:4]);
    assign w_offset     = {bus.addr[3:2], 2'b00};
    assign w_ramIdx     = bus.addr[AW+1:2];
    assign w_unusedAddr = &{1'b0, bus.addr[1:0]};

    assign w_mmioWr   = bus.we && w_mmioSel;
    assign w_ledWr    = w_mmioWr && (w_offset == OFF_LED);
    assign w_txPush   = w_mmioWr && (w_offset == OFF_TXDATA);
    assign w_statusWr = w_mmioWr && (w_offset == OFF_STATUS);
    assign w_cycleWr  = w_mmioWr && (w_offset == OFF_CYCLE);

    assign leds = r_leds;

    // RAM is deliberately left out of reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (bus.we && w_ramSel) begin
            r_mem[w_ramIdx] <= bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_leds     <= '0;
            r_cycle    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_ledWr) begin
                r_leds <= bus.wdata[7:0];
            end
            if (w_cycleWr) begin
                r_cycle <= bus.wdata;
            end else begin
                r_cycle <= r_cycle + 32'd1;
            end
            if (w_statusWr) begin
                r_overflow <= 1'b0;
            end else if (w_overflowSet) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_FULL]     = w_full;
        w_status[STAT_EMPTY]    = w_empty;
        w_status[STAT_BUSY]     = w_busy;
        w_status[STAT_OVERFLOW] = r_overflow;
    end

    always_comb begin
        bus.rdata = '0;
        if (w_ramSel) begin
            bus.rdata = r_mem[w_ramIdx];
        end else if (w_mmioSel) begin
            case (w_offset)
                OFF_LED:    bus.rdata = {24'b0, r_leds};
                OFF_STATUS: bus.rdata = {28'b0, w_status};
                OFF_CYCLE:  bus.rdata = r_cycle;
                default:    bus.rdata = '0;
            endcase
        end
    end

    uart_tx_core #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) u_uart (
        .clk           (clk),
        .reset         (reset),
        .i_push        (w_txPush),
        .i_pushData    (bus.wdata[7:0]),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_busy        (w_busy),
        .o_overflowSet (w_overflowSet),
        .o_tx          (uart_tx)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: register/RAM reads against an abstract
// model, UART frames decoded by a monitor and matched against a byte scoreboard.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
    localparam int MEM_WORDS  = 256;
    localparam int FRAME      = 10 * CLK_DIV;

    localparam logic [31:0] A_LED    = MMIO_BASE | 32'(OFF_LED);
    localparam logic [31:0] A_TXDATA = MMIO_BASE | 32'(OFF_TXDATA);
    localparam logic [31:0] A_STATUS = MMIO_BASE | 32'(OFF_STATUS);
    localparam logic [31:0] A_CYCLE  = MMIO_BASE | 32'(OFF_CYCLE);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] leds;
    logic       uart_tx;

    dmem_responder_if busIf();

    dmem_responder #(
        .MEM_WORDS  (MEM_WORDS),
        .FIFO_DEPTH (FIFO_DEPTH),
        .CLK_DIV    (CLK_DIV)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (busIf),
        .leds    (leds),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int edgeNo = 0;
    int rstEpoch = 0;
    always @(posedge clk) begin
        edgeNo <= edgeNo + 1;
        if (reset) rstEpoch <= rstEpoch + 1;
    end

    int nVec = 0;
    int nErr = 0;

    // Reference model state
    logic [7:0]  expQ[$];
    int          popEdges[$];
    logic        ovfModel = 1'b0;
    logic [7:0]  ledModel = 8'h00;
    logic [31:0] cycBase = 32'h0;
    int          cycEdge = 0;
    logic [31:0] ramModel [MEM_WORDS];
    int          ramWritten[$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nErr++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic w, input logic [31:0] d);
        @(negedge clk);
        busIf.addr  = a;
        busIf.we    = w;
        busIf.wdata = d;
        #1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(32'h2000_0000, 1'b0, 32'h0);
    endtask

    // Each accepted byte is popped one edge after its push, or one edge after
    // the previous frame finishes, whichever is later.
    task automatic modelPush(input logic [7:0] b, input int k);
        int  cnt;
        bit  popNow;
        int  p;
        cnt = 0;
        popNow = 0;
        foreach (popEdges[i]) begin
            if (popEdges[i] >= k) cnt++;
            if (popEdges[i] == k) popNow = 1;
        end
        if (cnt < FIFO_DEPTH || popNow) begin
            p = k + 1;
            if (popEdges.size() > 0 && popEdges[$] + FRAME + 1 > p) p = popEdges[$] + FRAME + 1;
            popEdges.push_back(p);
            expQ.push_back(b);
        end else begin
            ovfModel = 1'b1;
        end
    endtask

    function automatic logic [3:0] statusModel(input int e);
        int cnt;
        bit busy;
        cnt = 0;
        busy = 0;
        foreach (popEdges[i]) begin
            if (popEdges[i] > e) cnt++;
            if (popEdges[i] <= e && e - popEdges[i] < FRAME) busy = 1;
        end
        return {ovfModel, busy, cnt == 0, cnt == FIFO_DEPTH};
    endfunction

    function automatic logic [31:0] refRead(input logic [31:0] a);
        if (a < 32'(MEM_WORDS * 4)) return ramModel[a[9:2]];
        if (a[31:4] == MMIO_BASE[31:4]) begin
            case (a[3:2])
                2'd0:    return {24'b0, ledModel};
                2'd1:    return 32'b0;
                2'd2:    return {28'b0, statusModel(edgeNo)};
                default: return cycBase + 32'(edgeNo - cycEdge);
            endcase
        end
        return 32'b0;
    endfunction

    task automatic writeAndModel(input logic [31:0] a, input logic [31:0] d);
        int k;
        applyStimulus(a, 1'b1, d);
        k = edgeNo + 1;
        if (a < 32'(MEM_WORDS * 4)) begin
            ramModel[a[9:2]] = d;
            ramWritten.push_back(int'(a[9:2]));
        end else if (a[31:4] == MMIO_BASE[31:4]) begin
            case (a[3:2])
                2'd0:    ledModel = d[7:0];
                2'd1:    modelPush(d[7:0], k);
                2'd2:    ovfModel = 1'b0;
                default: begin cycBase = d; cycEdge = k; end
            endcase
        end
    endtask

    task automatic readCheck(input string name, input logic [31:0] a);
        applyStimulus(a, 1'b0, 32'h0);
        checkOutput(name, busIf.rdata, refRead(a));
    endtask

    task automatic waitDrain(input int limit);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < limit) begin
            idleCycles(1);
            n++;
        end
        idleCycles(FRAME);
        checkOutput("drain", 32'(expQ.size()), 32'd0);
    endtask

    // UART monitor: samples each bit mid-cell and matches bytes against expQ.
    initial begin
        int         ep;
        bit         aborted;
        logic [9:0] smp;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                ep = rstEpoch;
                aborted = 0;
                smp = '0;
                for (int j = 0; j < 10; j++) begin
                    repeat ((j == 0) ? 2 : CLK_DIV) @(negedge clk);
                    if (rstEpoch != ep) begin
                        aborted = 1;
                        break;
                    end
                    smp[j] = uart_tx;
                end
                if (!aborted) begin
                    checkOutput("startBit", {31'b0, smp[0]}, 32'd0);
                    checkOutput("stopBit", {31'b0, smp[9]}, 32'd1);
                    if (expQ.size() == 0) begin
                        nVec++;
                        nErr++;
                        $display("[TB] FAIL frameUnexpected: got byte %h, expected no frame", smp[8:1]);
                    end else begin
                        checkOutput("frameByte", {24'b0, smp[8:1]}, {24'b0, expQ.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          idx;

        busIf.addr = 32'h0;
        busIf.we = 1'b0;
        busIf.wdata = 32'h0;
        foreach (ramModel[i]) ramModel[i] = 32'h0;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cycEdge = edgeNo;
        busIf.addr = A_CYCLE;
        #1;
        checkOutput("rstCycle", busIf.rdata, 32'h0);
        checkOutput("rstLeds", {24'b0, leds}, 32'h0);
        checkOutput("rstTx", {31'b0, uart_tx}, 32'd1);
        readCheck("rstStatus", A_STATUS);

        // RAM write, aliased read, write-then-read in the same cycle
        writeAndModel(32'h0000_0010, 32'hDEAD_BEEF);
        readCheck("ram10", 32'h0000_0010);
        applyStimulus(32'h0000_0011, 1'b0, 32'h0);
        checkOutput("ram11", busIf.rdata, 32'hDEAD_BEEF);
        applyStimulus(32'h0000_0010, 1'b1, 32'h1234_5678);
        checkOutput("ramSameCycle", busIf.rdata, 32'hDEAD_BEEF);
        ramModel[4] = 32'h1234_5678;
        readCheck("ramNext", 32'h0000_0010);

        // LEDs and unmapped space
        writeAndModel(A_LED, 32'h0000_01A5);
        readCheck("ledRead", A_LED);
        checkOutput("ledPort", {24'b0, leds}, 32'h0000_00A5);
        readCheck("unmapped2000", 32'h2000_0000);
        readCheck("unmappedRamEnd", 32'h0000_0400);
        readCheck("unmappedMmioHole", 32'h1000_0010);
        readCheck("txdataRead", A_TXDATA);

        // Cycle counter wrap
        writeAndModel(A_CYCLE, 32'hFFFF_FFFE);
        applyStimulus(A_CYCLE, 1'b0, 32'h0);
        checkOutput("cycleN", busIf.rdata, 32'hFFFF_FFFE);
        applyStimulus(A_CYCLE, 1'b0, 32'h0);
        checkOutput("cycleN1", busIf.rdata, 32'hFFFF_FFFF);
        applyStimulus(A_CYCLE, 1'b0, 32'h0);
        checkOutput("cycleN2", busIf.rdata, 32'h0);

        // Single frame
        writeAndModel(A_TXDATA, 32'h0000_0055);
        applyStimulus(A_STATUS, 1'b0, 32'h0);
        checkOutput("txBeforePop", {31'b0, uart_tx}, 32'd1);
        checkOutput("statusQueued", busIf.rdata, refRead(A_STATUS));
        applyStimulus(A_STATUS, 1'b0, 32'h0);
        checkOutput("txStartLow", {31'b0, uart_tx}, 32'd0);
        checkOutput("statusBusy", busIf.rdata, 32'h0000_0006);
        idleCycles(FRAME + 5);
        applyStimulus(A_STATUS, 1'b0, 32'h0);
        checkOutput("statusIdle", busIf.rdata, 32'h0000_0002);

        // Overflow: ten pushes back to back, one popped early plus eight queued
        for (int i = 0; i < 10; i++) writeAndModel(A_TXDATA, 32'($urandom_range(0, 255)));
        applyStimulus(A_STATUS, 1'b0, 32'h0);
        checkOutput("ovfStatus", busIf.rdata, refRead(A_STATUS));
        checkOutput("ovfBit", {31'b0, busIf.rdata[STAT_OVERFLOW]}, 32'd1);
        writeAndModel(A_STATUS, 32'h0);
        applyStimulus(A_STATUS, 1'b0, 32'h0);
        checkOutput("ovfCleared", {31'b0, busIf.rdata[STAT_OVERFLOW]}, 32'd0);
        waitDrain(1000);

        // Random mix of accesses
        for (int i = 0; i < 120; i++) begin
            case ($urandom_range(0, 9))
                0, 1: begin
                    idx = $urandom_range(0, MEM_WORDS - 1);
                    a = {22'b0, 8'(idx), 2'($urandom_range(0, 3))};
                    writeAndModel(a, $urandom);
                end
                2: begin
                    if (ramWritten.size() > 0) begin
                        idx = ramWritten[$urandom_range(0, ramWritten.size() - 1)];
                        a = {22'b0, 8'(idx), 2'($urandom_range(0, 3))};
                        readCheck("ramRandom", a);
                    end
                end
                3: writeAndModel(A_LED, $urandom);
                4: readCheck("ledRandom", A_LED);
                5: begin
                    d = $urandom;
                    a = ($urandom_range(0, 1) == 0) ? {3'b001, d[28:0]} : {28'h1000_001, d[3:0]};
                    readCheck("unmappedRandom", a);
                end
                6: writeAndModel(A_TXDATA, 32'($urandom_range(0, 255)));
                7: readCheck("statusRandom", A_STATUS);
                8: readCheck("cycleRandom", A_CYCLE);
                default: begin
                    if ($urandom_range(0, 1) == 0) writeAndModel(A_CYCLE, $urandom);
                    else writeAndModel(A_STATUS, $urandom);
                end
            endcase
        end
        waitDrain(2000);

        // Reset in the middle of a data phase with a second byte queued
        writeAndModel(A_LED, 32'h0000_003C);
        writeAndModel(A_TXDATA, 32'h0000_00C3);
        writeAndModel(A_TXDATA, 32'h0000_003C);
        idleCycles(12);
        @(negedge clk);
        busIf.we = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        expQ.delete();
        popEdges.delete();
        ovfModel = 1'b0;
        ledModel = 8'h00;
        cycBase = 32'h0;
        cycEdge = edgeNo;
        busIf.addr = A_CYCLE;
        #1;
        checkOutput("midRstCycle", busIf.rdata, 32'h0);
        checkOutput("midRstTx", {31'b0, uart_tx}, 32'd1);
        checkOutput("midRstLeds", {24'b0, leds}, 32'h0);
        applyStimulus(A_STATUS, 1'b0, 32'h0);
        checkOutput("midRstStatus", busIf.rdata, 32'h0000_0002);
        readCheck("midRstRam", 32'h0000_0010);
        idleCycles(3 * FRAME);
        checkOutput("sbEmpty", 32'(expQ.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end

endmodule
